// File: rtl/event_sync_bank_if.sv
// event_sync_bank_if: groups the per-channel event signals of event_sync_bank.
// The master side drives the raw inputs, edge modes and acknowledges. The
// slave side (the synchroniser bank) returns levels, strobes, flags and counters.
interface event_sync_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       async_in;
  logic [2*CHANNELS-1:0]     edge_mode;
  logic [CHANNELS-1:0]       ack;
  logic [CHANNELS-1:0]       level_out;
  logic [CHANNELS-1:0]       pulse_out;
  logic [CHANNELS-1:0]       pending;
  logic [CHANNELS-1:0]       overflow;
  logic [CHANNELS*CNT_W-1:0] event_count;

  modport master (
    output async_in, edge_mode, ack,
    input  level_out, pulse_out, pending, overflow, event_count
  );

  modport slave (
    input  async_in, edge_mode, ack,
    output level_out, pulse_out, pending, overflow, event_count
  );
endinterface

// File: rtl/event_sync_bank.sv
// event_sync_bank: brings CHANNELS asynchronous inputs into the clk domain,
// optionally deglitches them, detects edges under per-channel mode control
// and reports each event as a strobe, a pending flag, a sticky overflow flag
// and a saturating counter.
// Optional feature macro: EVENT_SYNC_FILTER_EN builds the per-channel glitch
// filter; without it level_out is the last sync stage registered once.
module event_sync_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  event_sync_bank_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CHANNELS-1:0]    sync_last;
  logic [CHANNELS-1:0]    level_q;
  logic [CHANNELS-1:0]    prev_q;
  logic [CHANNELS-1:0]    rise;
  logic [CHANNELS-1:0]    fall;
  logic [CHANNELS-1:0]    evt;
  logic [CHANNELS-1:0]    pulse_q;
  logic [CHANNELS-1:0]    pend_q;
  logic [CHANNELS-1:0]    ovf_q;
  logic [CNT_W-1:0]       cnt_q [CHANNELS];

  // Shift each raw input through its synchroniser chain, stage 0 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '{default: '0};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], bus.async_in[c]};
      end
    end
  end

  // Only the final synchroniser stage is trusted as a clean level.
  always_comb begin
    sync_last = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sync_last[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

`ifdef EVENT_SYNC_FILTER_EN
  localparam int FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [FC_W-1:0] filt_cnt [CHANNELS];

  // Accept a new level only after it has disagreed with level_out for
  // FILTER_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= '0;
      filt_cnt <= '{default: '0};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync_last[c] == level_q[c]) begin
          filt_cnt[c] <= '0;
        end else if (filt_cnt[c] == FC_W'(FILTER_CYCLES - 1)) begin
          level_q[c]  <= sync_last[c];
          filt_cnt[c] <= '0;
        end else begin
          filt_cnt[c] <= filt_cnt[c] + FC_W'(1);
        end
      end
    end
  end
`else
  // Without the filter the level is the last sync stage plus one register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= sync_last;
    end
  end
`endif

  assign rise = level_q & ~prev_q;
  assign fall = ~level_q & prev_q;

  // An edge becomes an event when the live edge_mode bits enable it.
  always_comb begin
    evt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      evt[c] = (rise[c] & bus.edge_mode[2*c]) | (fall[c] & bus.edge_mode[2*c+1]);
    end
  end

  // Record events: strobe, pending/overflow flags and saturating counter,
  // with a same-cycle event taking precedence over the acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      prev_q  <= level_q;
      pulse_q <= evt;
      for (int c = 0; c < CHANNELS; c++) begin
        if (evt[c] && bus.ack[c]) begin
          pend_q[c] <= 1'b1;
          ovf_q[c]  <= 1'b0;
          cnt_q[c]  <= CNT_W'(1);
        end else if (evt[c]) begin
          pend_q[c] <= 1'b1;
          ovf_q[c]  <= ovf_q[c] | pend_q[c];
          if (cnt_q[c] != {CNT_W{1'b1}}) begin
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end
        end else if (bus.ack[c]) begin
          pend_q[c] <= 1'b0;
          ovf_q[c]  <= 1'b0;
          cnt_q[c]  <= '0;
        end
      end
    end
  end

  assign bus.level_out = level_q;
  assign bus.pulse_out = pulse_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;

  // Flatten the per-channel counters onto the output bus.
  always_comb begin
    bus.event_count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.event_count[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

endmodule

// File: tb/tb_event_sync_bank.sv
// tb_event_sync_bank: directed scenarios with fixed expectations plus a
// randomized run checked against a cycle-level behavioural model of the bank.
module tb_event_sync_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef EVENT_SYNC_FILTER_EN
  localparam int LAT  = SS + FC;
  localparam int FILT = 1;
`else
  localparam int LAT  = SS + 1;
  localparam int FILT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  event_sync_bank_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();
  event_sync_bank_if #(.CHANNELS(1), .CNT_W(2))   bus_s ();

  event_sync_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  event_sync_bank #(
    .CHANNELS(1), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  always #5 clk = ~clk;

  // Behavioural model: delayed samples, a persistence rule for the filter,
  // and plain integer bookkeeping for flags and the counter.
  int m_sync  [CH][SS];
  int m_level [CH];
  int m_prev  [CH];
  int m_run   [CH];
  int m_pulse [CH];
  int m_pend  [CH];
  int m_ovf   [CH];
  int m_cnt   [CH];
  int s_old, l_old, evt_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < SS; k++) m_sync[c][k] = 0;
        m_level[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_pulse[c] = 0;
        m_pend[c] = 0; m_ovf[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        s_old = m_sync[c][SS-1];
        l_old = m_level[c];
        evt_m = ((l_old == 1 && m_prev[c] == 0 && bus.edge_mode[2*c]) ||
                 (l_old == 0 && m_prev[c] == 1 && bus.edge_mode[2*c+1])) ? 1 : 0;
        m_prev[c] = l_old;
        if (FILT == 1) begin
          if (s_old != l_old) begin
            m_run[c] = m_run[c] + 1;
            if (m_run[c] >= FC) begin
              m_level[c] = s_old;
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end else begin
          m_level[c] = s_old;
        end
        for (int k = SS - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
        m_sync[c][0] = bus.async_in[c] ? 1 : 0;
        m_pulse[c] = evt_m;
        if (evt_m == 1 && bus.ack[c]) begin
          m_pend[c] = 1; m_ovf[c] = 0; m_cnt[c] = 1;
        end else if (evt_m == 1) begin
          if (m_pend[c] == 1) m_ovf[c] = 1;
          m_pend[c] = 1;
          m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
        end else if (bus.ack[c]) begin
          m_pend[c] = 0; m_ovf[c] = 0; m_cnt[c] = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.async_in = '0; bus.edge_mode = '0; bus.ack = '0;
    bus_s.async_in = '0; bus_s.edge_mode = 2'b11; bus_s.ack = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.async_in = 4'($urandom); bus.edge_mode = 8'hFF; bus.ack = '0;
    bus_s.async_in = '0; bus_s.edge_mode = 2'b11; bus_s.ack = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.level_out !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_level got %b expected 0000", bus.level_out); end
    n_checks++; if (bus.pulse_out !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_pulse got %b expected 0000", bus.pulse_out); end
    n_checks++; if (bus.pending !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_pending got %b expected 0000", bus.pending); end
    n_checks++; if (bus.overflow !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_overflow got %b expected 0000", bus.overflow); end
    n_checks++; if (bus.event_count !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_count got %h expected 0", bus.event_count); end
  endtask

  task automatic test_rise_latency();
    do_reset();
    bus.edge_mode = 8'b00_00_00_01;
    bus.async_in[0] = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (bus.level_out[0] !== (e >= LAT)) begin
        n_fail++; $display("[TB] FAIL rise_level edge %0d got %b expected %b", e, bus.level_out[0], (e >= LAT));
      end
      n_checks++;
      if (bus.pulse_out[0] !== (e == LAT + 1)) begin
        n_fail++; $display("[TB] FAIL rise_pulse edge %0d got %b expected %b", e, bus.pulse_out[0], (e == LAT + 1));
      end
    end
    n_checks++; if (bus.pending[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL rise_pending got %b expected 1", bus.pending[0]); end
    n_checks++; if (bus.event_count[0 +: CW] !== 8'd1) begin n_fail++; $display("[TB] FAIL rise_count got %0d expected 1", bus.event_count[0 +: CW]); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int lvl_seen = 0;
    do_reset();
    bus.edge_mode = 8'b00_00_01_00;
    for (int i = 0; i < 25; i++) begin
      bus.async_in[1] = (i < 3);
      @(negedge clk);
      if (bus.pulse_out[1]) pulses++;
      if (bus.level_out[1]) lvl_seen = 1;
    end
    n_checks++; if (pulses != FILT ? 0 : 0) begin end
    n_checks--;
    n_checks++; if (pulses !== (FILT ? 0 : 1)) begin n_fail++; $display("[TB] FAIL glitch_pulses got %0d expected %0d", pulses, (FILT ? 0 : 1)); end
    n_checks++; if (lvl_seen !== (FILT ? 0 : 1)) begin n_fail++; $display("[TB] FAIL glitch_level got %0d expected %0d", lvl_seen, (FILT ? 0 : 1)); end
    n_checks++; if (bus.pending[1] !== (FILT ? 1'b0 : 1'b1)) begin n_fail++; $display("[TB] FAIL glitch_pending got %b expected %0d", bus.pending[1], (FILT ? 0 : 1)); end
    n_checks++; if (bus.event_count[CW +: CW] !== (FILT ? 8'd0 : 8'd1)) begin n_fail++; $display("[TB] FAIL glitch_count got %0d expected %0d", bus.event_count[CW +: CW], (FILT ? 0 : 1)); end
  endtask

  task automatic test_both_overflow();
    int pulses = 0;
    do_reset();
    bus.edge_mode = 8'b00_11_00_00;
    for (int t = 0; t < 3; t++) begin
      bus.async_in[2] = ~bus.async_in[2];
      repeat (10) begin
        @(negedge clk);
        if (bus.pulse_out[2]) pulses++;
      end
    end
    n_checks++; if (pulses !== 3) begin n_fail++; $display("[TB] FAIL both_pulses got %0d expected 3", pulses); end
    n_checks++; if (bus.event_count[2*CW +: CW] !== 8'd3) begin n_fail++; $display("[TB] FAIL both_count got %0d expected 3", bus.event_count[2*CW +: CW]); end
    n_checks++; if (bus.overflow[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL both_overflow got %b expected 1", bus.overflow[2]); end
    n_checks++; if (bus.pending[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL both_pending got %b expected 1", bus.pending[2]); end
    bus.ack[2] = 1'b1;
    @(negedge clk);
    bus.ack[2] = 1'b0;
    n_checks++; if (bus.pending[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_pending got %b expected 0", bus.pending[2]); end
    n_checks++; if (bus.overflow[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_overflow got %b expected 0", bus.overflow[2]); end
    n_checks++; if (bus.event_count[2*CW +: CW] !== 8'd0) begin n_fail++; $display("[TB] FAIL ack_count got %0d expected 0", bus.event_count[2*CW +: CW]); end
  endtask

  task automatic test_ack_collision();
    do_reset();
    bus.edge_mode = 8'b11_00_00_00;
    for (int t = 0; t < 2; t++) begin
      bus.async_in[3] = ~bus.async_in[3];
      repeat (10) @(negedge clk);
    end
    n_checks++; if (bus.overflow[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_pre_overflow got %b expected 1", bus.overflow[3]); end
    n_checks++; if (bus.event_count[3*CW +: CW] !== 8'd2) begin n_fail++; $display("[TB] FAIL coll_pre_count got %0d expected 2", bus.event_count[3*CW +: CW]); end
    bus.async_in[3] = ~bus.async_in[3];
    repeat (LAT) @(negedge clk);
    bus.ack[3] = 1'b1;
    @(negedge clk);
    bus.ack[3] = 1'b0;
    n_checks++; if (bus.pulse_out[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_pulse got %b expected 1", bus.pulse_out[3]); end
    n_checks++; if (bus.pending[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_pending got %b expected 1", bus.pending[3]); end
    n_checks++; if (bus.event_count[3*CW +: CW] !== 8'd1) begin n_fail++; $display("[TB] FAIL coll_count got %0d expected 1", bus.event_count[3*CW +: CW]); end
    n_checks++; if (bus.overflow[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_overflow got %b expected 0", bus.overflow[3]); end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      bus_s.async_in[0] = ~bus_s.async_in[0];
      repeat (10) begin
        @(negedge clk);
        if (bus_s.pulse_out[0]) pulses++;
      end
    end
    n_checks++; if (pulses !== 5) begin n_fail++; $display("[TB] FAIL sat_pulses got %0d expected 5", pulses); end
    n_checks++; if (bus_s.event_count !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_count got %0d expected 3", bus_s.event_count); end
    n_checks++; if (bus_s.overflow[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_overflow got %b expected 1", bus_s.overflow[0]); end
  endtask

  task automatic test_reset_release_high();
    int pulses = 0;
    int pulse_edge = -1;
    @(negedge clk);
    reset = 1'b1;
    bus.async_in = 4'b0001; bus.edge_mode = 8'b00_00_00_01; bus.ack = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= LAT + 6; e++) begin
      @(negedge clk);
      if (bus.pulse_out[0]) begin
        pulses++;
        pulse_edge = e;
      end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("[TB] FAIL release_pulses got %0d expected 1", pulses); end
    n_checks++; if (pulse_edge !== LAT + 1) begin n_fail++; $display("[TB] FAIL release_edge got %0d expected %0d", pulse_edge, LAT + 1); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int lvl_seen = 0;
    do_reset();
    bus.edge_mode = 8'b00_00_01_01;
    bus.async_in[1] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    bus.async_in[0] = 1'b1;
    repeat (LAT - 2) @(negedge clk);
    #2;
    reset = 1'b1;
    bus.async_in = '0;
    #1;
    n_checks++; if (bus.level_out !== 4'h0) begin n_fail++; $display("[TB] FAIL mid_level got %b expected 0000", bus.level_out); end
    n_checks++; if (bus.pending !== 4'h0) begin n_fail++; $display("[TB] FAIL mid_pending got %b expected 0000", bus.pending); end
    n_checks++; if (bus.event_count !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_count got %h expected 0", bus.event_count); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pulse_out != 0) pulses++;
      if (bus.level_out != 0) lvl_seen = 1;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("[TB] FAIL mid_stale_pulse got %0d expected 0", pulses); end
    n_checks++; if (lvl_seen !== 0) begin n_fail++; $display("[TB] FAIL mid_stale_level got %0d expected 0", lvl_seen); end
  endtask

  task automatic test_random();
    int hold [CH];
    logic [CH-1:0]    e_level, e_pulse, e_pend, e_ovf;
    logic [CH*CW-1:0] e_cnt;
    do_reset();
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 12);
    bus.edge_mode = 8'($urandom);
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        e_level[c] = (m_level[c] != 0);
        e_pulse[c] = (m_pulse[c] != 0);
        e_pend[c]  = (m_pend[c] != 0);
        e_ovf[c]   = (m_ovf[c] != 0);
        e_cnt[c*CW +: CW] = CW'(m_cnt[c]);
      end
      n_checks++; if (bus.level_out !== e_level) begin n_fail++; $display("[TB] FAIL rnd_level cyc %0d got %b expected %b", cyc, bus.level_out, e_level); end
      n_checks++; if (bus.pulse_out !== e_pulse) begin n_fail++; $display("[TB] FAIL rnd_pulse cyc %0d got %b expected %b", cyc, bus.pulse_out, e_pulse); end
      n_checks++; if (bus.pending !== e_pend) begin n_fail++; $display("[TB] FAIL rnd_pending cyc %0d got %b expected %b", cyc, bus.pending, e_pend); end
      n_checks++; if (bus.overflow !== e_ovf) begin n_fail++; $display("[TB] FAIL rnd_overflow cyc %0d got %b expected %b", cyc, bus.overflow, e_ovf); end
      n_checks++; if (bus.event_count !== e_cnt) begin n_fail++; $display("[TB] FAIL rnd_count cyc %0d got %h expected %h", cyc, bus.event_count, e_cnt); end
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          bus.async_in[c] = ~bus.async_in[c];
          hold[c] = $urandom_range(1, 12);
        end
        bus.ack[c] = ($urandom_range(0, 9) == 0);
      end
      if ((cyc % 40) == 39) bus.edge_mode = 8'($urandom);
    end
    bus.ack = '0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_both_overflow();
    test_ack_collision();
    test_saturate();
    test_reset_release_high();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_sync_bank.md
# event_sync_bank

Multi-channel asynchronous-event synchroniser: brings `CHANNELS` independent asynchronous inputs (switches, keys, external strobes) into the `clk` domain through a parametrised flop chain. It optionally deglitches each input, then detects rising, falling or both edges per channel under runtime mode control. Each detected event produces a one-cycle pulse, a held `pending` flag with `ack` handshake, a sticky overflow flag and a saturating event counter. It sits at the board-I/O boundary and feeds control FSMs that cannot see every pulse.

## Interface
- `CHANNELS`, 4: number of independent channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `FILTER_CYCLES`, 4: consecutive cycles a new level must persist before acceptance, ≥1 (used only with filter compiled in).
- `CNT_W`, 8: width of each per-channel event counter, ≥1.

Ports:
- `clk` in 1: sole clock; all state is in this domain.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `async_in` in CHANNELS: raw asynchronous inputs; never used as a clock.
- `edge_mode` in 2*CHANNELS: per channel `[2c+1:2c]`; 00 off, 01 rising, 10 falling, 11 both.
- `ack` in CHANNELS: consumer acknowledge, sampled each `clk` edge.
- `level_out` out CHANNELS: synchronised, filtered level.
- `pulse_out` out CHANNELS: one-cycle event strobe.
- `pending` out CHANNELS: event held until acknowledged.
- `overflow` out CHANNELS: sticky, set when an event arrives while `pending` is already set.
- `event_count` out CHANNELS*CNT_W: per-channel counter, channel c at `[c*CNT_W +: CNT_W]`.

## Operation
- Reset: all sync flops, `level_out`, previous-level register, filter counters, `pulse_out`, `pending`, `overflow`, `event_count` go to 0.
- Sync chain: `SYNC_STAGES` flops per channel. Only the last stage is observed.
- Filter: a counter runs while the last sync stage differs from `level_out` and clears to 0 whenever they are equal. When the mismatch has lasted `FILTER_CYCLES` consecutive cycles, `level_out` takes the new value and the counter clears. A glitch shorter than `FILTER_CYCLES` cycles never changes `level_out`.
- Edge detect: rise = `level_out` & !prev; fall = !`level_out` & prev. The event fires when the mode enables that edge. Mode 00 suppresses events while `level_out` still tracks the input.
- `edge_mode` is sampled each cycle, not latched. A change applies to the next detected edge.
- On an event: `pulse_out`=1 for exactly one cycle, `pending`←1, `event_count`←`event_count`+1, saturating at 2^CNT_W−1.
- `ack` in a cycle clears `pending`, `overflow` and `event_count` to 0 at that edge.
- Event and `ack` in the same cycle: the new event wins. `pending`=1, `event_count`=1, `overflow`=0.
- Event while `pending`=1 and no `ack`: `overflow`←1 (sticky) and the counter still increments.
- Input high when `reset` deasserts: prev=0, so a rising event is reported once the level propagates. This is intended.
- Channels are fully independent. There is no cross-channel priority.

## Timing
- Filter compiled in: an input change stable from edge 0 appears on `level_out` after `SYNC_STAGES`+`FILTER_CYCLES` edges.
- Filter compiled out: `level_out` is the last sync stage registered once, so it appears after `SYNC_STAGES`+1 edges.
- `pulse_out`, `pending`, `overflow` and `event_count` update one edge after `level_out` changes.
- Minimum event spacing is one level change per `FILTER_CYCLES` cycles. Faster toggling is filtered, not queued.
- `reset` asserted mid-operation clears all state asynchronously. The first edge after release restarts the sync chain.

## Configuration
- `EVENT_SYNC_FILTER_EN` defined: per-channel glitch filter and its counters are built as above.
- `EVENT_SYNC_FILTER_EN` undefined: no filter logic. `FILTER_CYCLES` is ignored and `level_out` follows the sync chain with a fixed one-register delay.

## Test plan
- Filter on, SYNC_STAGES=2, FILTER_CYCLES=4, ch0 mode 01, raise `async_in[0]` and hold -> `level_out[0]`=1 at edge 6, `pulse_out[0]`=1 at edge 7 only, `pending[0]`=1, `event_count[0]`=1.
- 3-cycle high glitch on ch1 with filter on -> `level_out[1]`, `pulse_out[1]` and `pending[1]` stay 0. Repeat with filter off -> one pulse, `event_count[1]`=1.
- Ch2 mode 11, toggle input 3 times spaced 10 cycles, no `ack` -> 3 pulses, `event_count[2]`=3, `overflow[2]`=1. Then `ack[2]` -> pending, overflow and count all 0.
- Event and `ack` on ch3 in the same cycle while pending=1, overflow=1 -> `pending`=1, `event_count`=1, `overflow`=0.
- CNT_W=2, 5 events without `ack` -> `event_count` saturates at 3.
- `reset` asserted with input high, then released -> one rising pulse after the nominal latency. Assert `reset` mid-filter-count -> all outputs 0 immediately and no stale pulse follows.
